// File: rtl/awg_cmd_pkg.sv
// Shared constants for the AWG framed command sequencer: command codes, error codes,
// FSM state encodings, reset defaults and response bytes.
package awg_cmd_pkg;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

    localparam logic [7:0] CMD_WAVE   = 8'h01;
    localparam logic [7:0] CMD_FREQ   = 8'h02;
    localparam logic [7:0] CMD_AMP    = 8'h03;
    localparam logic [7:0] CMD_OFS    = 8'h04;
    localparam logic [7:0] CMD_COMMIT = 8'h05;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_CHECKSUM = 2'd1;
    localparam logic [1:0] ERR_CMD      = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CMD     = 2'd1;
    localparam logic [1:0] ST_PAYLOAD = 2'd2;
    localparam logic [1:0] ST_CHECK   = 2'd3;

    localparam logic [1:0]  WAVE_RST = 2'd0;
    localparam logic [15:0] FREQ_RST = 16'h0001;
    localparam logic [9:0]  AMP_RST  = 10'h3FF;
    localparam logic [9:0]  OFS_RST  = 10'h200;

    localparam logic [7:0] RESP_ACK = 8'h06;
    localparam logic [7:0] RESP_NAK = 8'h15;

    function automatic logic cmd_known(input logic [7:0] cmd);
        return (cmd >= CMD_WAVE) && (cmd <= CMD_COMMIT);
    endfunction

    function automatic logic [1:0] cmd_payload_len(input logic [7:0] cmd);
        case (cmd)
            CMD_WAVE:                  return 2'd1;
            CMD_FREQ, CMD_AMP, CMD_OFS: return 2'd2;
            default:                   return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/awg_byte_timeout.sv
// Inter-byte watchdog: counts idle cycles while enabled and pulses expire on the cycle
// the count would reach TIMEOUT_CYCLES-1; a clear in that same cycle suppresses it.
module awg_byte_timeout
    import awg_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic expire
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES - 1) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 2);

    logic [CW-1:0] cnt_q, cnt_d;

    assign expire = enable && !clear && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear || !enable || expire) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/awg_cmd_sequencer.sv
// Framed UART command decoder: SYNC, CMD, payload, XOR CHK into shadow registers, with an
// atomic commit to the live outputs. Define AWG_CMD_ACK_EN to add the ACK/NAK response port.
module awg_cmd_sequencer
    import awg_cmd_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 100000,
    parameter logic [7:0] SYNC_BYTE      = SYNC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  uart_data,
    input  logic        data_valid,
    output logic [1:0]  waveform_type,
    output logic [15:0] frequency,
    output logic [9:0]  amplitude,
    output logic [9:0]  dc_offset,
    output logic        cfg_update,
    output logic        pkt_err,
    output logic [1:0]  err_code,
    output logic        busy
`ifdef AWG_CMD_ACK_EN
    ,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
`endif
);

    logic [1:0]  state_q, state_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [15:0] asm_q, asm_d;
    logic [7:0]  chk_q, chk_d;
    logic [1:0]  wave_s_q, wave_s_d, wave_q, wave_d;
    logic [15:0] freq_s_q, freq_s_d, freq_q, freq_d;
    logic [9:0]  amp_s_q, amp_s_d, amp_q, amp_d;
    logic [9:0]  ofs_s_q, ofs_s_d, ofs_q, ofs_d;
    logic        cfg_update_q, cfg_update_d;
    logic        pkt_err_q, pkt_err_d;
    logic [1:0]  err_code_q, err_code_d;
    logic        expire;
    logic [1:0]  pay_len;

    awg_byte_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (state_q != ST_IDLE),
        .clear  (data_valid),
        .expire (expire)
    );

    assign pay_len = cmd_payload_len(uart_data);

    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        cnt_d        = cnt_q;
        asm_d        = asm_q;
        chk_d        = chk_q;
        wave_s_d     = wave_s_q;
        freq_s_d     = freq_s_q;
        amp_s_d      = amp_s_q;
        ofs_s_d      = ofs_s_q;
        wave_d       = wave_q;
        freq_d       = freq_q;
        amp_d        = amp_q;
        ofs_d        = ofs_q;
        cfg_update_d = 1'b0;
        pkt_err_d    = 1'b0;
        err_code_d   = err_code_q;
        if (expire) begin
            state_d    = ST_IDLE;
            pkt_err_d  = 1'b1;
            err_code_d = ERR_TIMEOUT;
        end else if (data_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (uart_data == SYNC_BYTE) state_d = ST_CMD;
                end
                ST_CMD: begin
                    if (cmd_known(uart_data)) begin
                        cmd_d   = uart_data;
                        chk_d   = uart_data;
                        cnt_d   = pay_len;
                        asm_d   = '0;
                        state_d = (pay_len == 2'd0) ? ST_CHECK : ST_PAYLOAD;
                    end else begin
                        state_d    = ST_IDLE;
                        pkt_err_d  = 1'b1;
                        err_code_d = ERR_CMD;
                    end
                end
                ST_PAYLOAD: begin
                    // MSB-first: after the last byte, asm_q holds the payload right-aligned.
                    asm_d = {asm_q[7:0], uart_data};
                    chk_d = chk_q ^ uart_data;
                    cnt_d = cnt_q - 2'd1;
                    if (cnt_q == 2'd1) state_d = ST_CHECK;
                end
                default: begin
                    state_d = ST_IDLE;
                    if (uart_data != chk_q) begin
                        pkt_err_d  = 1'b1;
                        err_code_d = ERR_CHECKSUM;
                    end else begin
                        case (cmd_q)
                            CMD_WAVE: wave_s_d = asm_q[1:0];
                            CMD_FREQ: begin
                                if (asm_q == 16'h0000) begin
                                    pkt_err_d  = 1'b1;
                                    err_code_d = ERR_CMD;
                                end else begin
                                    freq_s_d = asm_q;
                                end
                            end
                            CMD_AMP:  amp_s_d = asm_q[9:0];
                            CMD_OFS:  ofs_s_d = asm_q[9:0];
                            default: begin
                                wave_d       = wave_s_q;
                                freq_d       = freq_s_q;
                                amp_d        = amp_s_q;
                                ofs_d        = ofs_s_q;
                                cfg_update_d = 1'b1;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cmd_q        <= 8'h00;
            cnt_q        <= 2'd0;
            asm_q        <= 16'h0000;
            chk_q        <= 8'h00;
            wave_s_q     <= WAVE_RST;
            freq_s_q     <= FREQ_RST;
            amp_s_q      <= AMP_RST;
            ofs_s_q      <= OFS_RST;
            wave_q       <= WAVE_RST;
            freq_q       <= FREQ_RST;
            amp_q        <= AMP_RST;
            ofs_q        <= OFS_RST;
            cfg_update_q <= 1'b0;
            pkt_err_q    <= 1'b0;
            err_code_q   <= ERR_NONE;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            cnt_q        <= cnt_d;
            asm_q        <= asm_d;
            chk_q        <= chk_d;
            wave_s_q     <= wave_s_d;
            freq_s_q     <= freq_s_d;
            amp_s_q      <= amp_s_d;
            ofs_s_q      <= ofs_s_d;
            wave_q       <= wave_d;
            freq_q       <= freq_d;
            amp_q        <= amp_d;
            ofs_q        <= ofs_d;
            cfg_update_q <= cfg_update_d;
            pkt_err_q    <= pkt_err_d;
            err_code_q   <= err_code_d;
        end
    end

    assign waveform_type = wave_q;
    assign frequency     = freq_q;
    assign amplitude     = amp_q;
    assign dc_offset     = ofs_q;
    assign cfg_update    = cfg_update_q;
    assign pkt_err       = pkt_err_q;
    assign err_code      = err_code_q;
    assign busy          = (state_q != ST_IDLE);

`ifdef AWG_CMD_ACK_EN
    // valid/ready: tx_data is stable while tx_valid is high until a cycle with tx_ready high;
    // a newer response overwrites a pending one and keeps tx_valid asserted.
    logic       tx_valid_q;
    logic [7:0] tx_data_q;
    logic       resp_fire;

    assign resp_fire = pkt_err_d || (data_valid && (state_q == ST_CHECK));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else if (resp_fire) begin
            tx_valid_q <= 1'b1;
            tx_data_q  <= pkt_err_d ? RESP_NAK : RESP_ACK;
        end else if (tx_ready) begin
            tx_valid_q <= 1'b0;
        end
    end

    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_data_q;
`endif

endmodule

// File: tb/tb_awg_cmd_sequencer.sv
// Self-checking bench for awg_cmd_sequencer: packet table with expected live state, an
// event scoreboard for cfg_update/pkt_err pulses, and hand-written timing/reset sequences.
module tb_awg_cmd_sequencer;
  import awg_cmd_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [7:0]  uart_data;
  logic        data_valid;
  logic [1:0]  waveform_type;
  logic [15:0] frequency;
  logic [9:0]  amplitude;
  logic [9:0]  dc_offset;
  logic        cfg_update;
  logic        pkt_err;
  logic [1:0]  err_code;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // Event record: {is_err, err_code, wave, freq, amp, ofs}
  logic [40:0] exp_q[$];

  typedef struct {
    int          n;
    logic [47:0] bytes;
    int          kind;
    logic [1:0]  wave;
    logic [15:0] freq;
    logic [9:0]  amp;
    logic [9:0]  ofs;
    logic [1:0]  err;
  } vec_t;

  vec_t vt[14];

  awg_cmd_sequencer #(.TIMEOUT_CYCLES(16), .SYNC_BYTE(8'hA5)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .uart_data     (uart_data),
    .data_valid    (data_valid),
    .waveform_type (waveform_type),
    .frequency     (frequency),
    .amplitude     (amplitude),
    .dc_offset     (dc_offset),
    .cfg_update    (cfg_update),
    .pkt_err       (pkt_err),
    .err_code      (err_code),
    .busy          (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [40:0] commit_evt(input logic [1:0] w, input logic [15:0] f,
                                             input logic [9:0] a, input logic [9:0] o);
    return {1'b0, 2'b00, w, f, a, o};
  endfunction

  function automatic logic [40:0] err_evt(input logic [1:0] e);
    return {1'b1, e, 38'd0};
  endfunction

  function automatic vec_t mk(input int n, input logic [47:0] b, input int kind,
                              input logic [1:0] w, input logic [15:0] f, input logic [9:0] a,
                              input logic [9:0] o, input logic [1:0] e);
    vec_t v;
    v.n = n; v.bytes = b; v.kind = kind;
    v.wave = w; v.freq = f; v.amp = a; v.ofs = o; v.err = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [40:0] got, input logic [40:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic check_live(input string name, input logic [1:0] w, input logic [15:0] f,
                            input logic [9:0] a, input logic [9:0] o);
    check(name, {3'b000, waveform_type, frequency, amplitude, dc_offset}, commit_evt(w, f, a, o));
  endtask

  // driver tasks: called at a negedge, return at the next negedge
  task automatic send_byte(input logic [7:0] b);
    uart_data  = b;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic send_pkt(input int n, input logic [47:0] b);
    logic [47:0] t;
    t = b;
    for (int i = 0; i < n; i++) begin
      send_byte(t[47:40]);
      t = t << 8;
    end
  endtask

  // scoreboard: every cfg_update/pkt_err pulse must match the oldest expectation
  task automatic monitor();
    logic [40:0] act;
    logic [40:0] exp_v;
    forever begin
      @(negedge clk);
      if (rst_n && (cfg_update || pkt_err)) begin
        act = pkt_err ? {1'b1, err_code, 38'd0}
                      : {1'b0, 2'b00, waveform_type, frequency, amplitude, dc_offset};
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event got %h want none", act);
        end else begin
          exp_v = exp_q.pop_front();
          check("event", act, exp_v);
        end
      end
    end
  endtask

  initial begin
    int k;
    rst_n      = 1'b0;
    uart_data  = 8'h00;
    data_valid = 1'b0;

    vt[0]  = mk(5, 48'hA5_02_12_34_24_00, 0, 2'd0, 16'h0001, 10'h3FF, 10'h200, 2'd0);
    vt[1]  = mk(3, 48'hA5_05_05_00_00_00, 1, 2'd0, 16'h1234, 10'h3FF, 10'h200, 2'd0);
    vt[2]  = mk(5, 48'hA5_03_01_FF_00_00, 2, 2'd0, 16'h1234, 10'h3FF, 10'h200, 2'd1);
    vt[3]  = mk(3, 48'hA5_05_05_00_00_00, 1, 2'd0, 16'h1234, 10'h3FF, 10'h200, 2'd1);
    vt[4]  = mk(2, 48'hA5_07_00_00_00_00, 2, 2'd0, 16'h1234, 10'h3FF, 10'h200, 2'd2);
    vt[5]  = mk(4, 48'hA5_01_02_03_00_00, 0, 2'd0, 16'h1234, 10'h3FF, 10'h200, 2'd2);
    vt[6]  = mk(5, 48'hA5_02_00_00_02_00, 2, 2'd0, 16'h1234, 10'h3FF, 10'h200, 2'd2);
    vt[7]  = mk(3, 48'hA5_05_05_00_00_00, 1, 2'd2, 16'h1234, 10'h3FF, 10'h200, 2'd2);
    vt[8]  = mk(6, 48'h3C_A5_03_02_AA_AB, 0, 2'd2, 16'h1234, 10'h3FF, 10'h200, 2'd2);
    vt[9]  = mk(5, 48'hA5_04_03_FF_F8_00, 0, 2'd2, 16'h1234, 10'h3FF, 10'h200, 2'd2);
    vt[10] = mk(4, 48'hA5_01_FD_FC_00_00, 0, 2'd2, 16'h1234, 10'h3FF, 10'h200, 2'd2);
    vt[11] = mk(3, 48'hA5_05_05_00_00_00, 1, 2'd1, 16'h1234, 10'h2AA, 10'h3FF, 2'd2);
    vt[12] = mk(5, 48'hA5_02_A5_00_A7_00, 0, 2'd1, 16'h1234, 10'h2AA, 10'h3FF, 2'd2);
    vt[13] = mk(3, 48'hA5_05_05_00_00_00, 1, 2'd1, 16'hA500, 10'h2AA, 10'h3FF, 2'd2);

    idle(3);
    check_live("reset_live", WAVE_RST, FREQ_RST, AMP_RST, OFS_RST);
    check("reset_flags", {cfg_update, pkt_err, err_code, busy}, 5'b0);
    rst_n = 1'b1;
    idle(2);
    fork
      monitor();
    join_none

    // table-driven packets
    for (int i = 0; i < 14; i++) begin
      if (vt[i].kind == 1) exp_q.push_back(commit_evt(vt[i].wave, vt[i].freq, vt[i].amp, vt[i].ofs));
      if (vt[i].kind == 2) exp_q.push_back(err_evt(vt[i].err));
      send_pkt(vt[i].n, vt[i].bytes);
      check($sformatf("pulse_latency_%0d", i), {cfg_update | pkt_err, busy},
            {(vt[i].kind != 0) ? 1'b1 : 1'b0, 1'b0});
      idle(1);
      check($sformatf("pulse_width_%0d", i), {cfg_update, pkt_err}, 2'b00);
      check_live($sformatf("live_%0d", i), vt[i].wave, vt[i].freq, vt[i].amp, vt[i].ofs);
      check($sformatf("err_code_%0d", i), err_code, vt[i].err);
    end

    // two full packets back-to-back with no idle cycles
    exp_q.push_back(commit_evt(2'd1, 16'hBEEF, 10'h2AA, 10'h3FF));
    send_pkt(5, 48'hA5_02_BE_EF_53_00);
    send_pkt(3, 48'hA5_05_05_00_00_00);
    idle(1);
    check_live("b2b_live", 2'd1, 16'hBEEF, 10'h2AA, 10'h3FF);

    // timeout: pkt_err 15 cycles after the last byte
    exp_q.push_back(err_evt(ERR_TIMEOUT));
    send_pkt(2, 48'hA5_04_00_00_00_00);
    k = 0;
    while (!pkt_err && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("timeout_cycle", 41'(k), 41'd15);
    check("timeout_state", {err_code, busy}, {ERR_TIMEOUT, 1'b0});
    idle(3);

    // a byte arriving in the expiry cycle wins
    exp_q.push_back(commit_evt(2'd1, 16'hBEEF, 10'h2AA, 10'h100));
    send_pkt(2, 48'hA5_04_00_00_00_00);
    idle(14);
    send_byte(8'h01);
    idle(14);
    send_byte(8'h00);
    idle(14);
    send_byte(8'h05);
    check("expiry_byte_wins", {err_code, busy}, {ERR_TIMEOUT, 1'b0});
    send_pkt(3, 48'hA5_05_05_00_00_00);
    idle(1);
    check_live("expiry_commit", 2'd1, 16'hBEEF, 10'h2AA, 10'h100);

    // reset mid-payload discards everything
    send_pkt(3, 48'hA5_03_01_00_00_00);
    rst_n = 1'b0;
    idle(2);
    check_live("midreset_live", WAVE_RST, FREQ_RST, AMP_RST, OFS_RST);
    check("midreset_flags", {cfg_update, pkt_err, err_code, busy}, 5'b0);
    rst_n = 1'b1;
    idle(1);
    exp_q.push_back(commit_evt(WAVE_RST, FREQ_RST, AMP_RST, OFS_RST));
    send_pkt(3, 48'hA5_05_05_00_00_00);
    idle(2);
    check_live("post_reset_commit", WAVE_RST, FREQ_RST, AMP_RST, OFS_RST);

    check("scoreboard_drained", 41'(exp_q.size()), 41'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
